ledger_mem_arbiter: RTL
=======================

Name: ledger_mem_arbiter

Overview:
- Shares the single-port 48-bit ledger RAM between three requesters: 0 = memory controller (block load/store), 1 = mining unit (previous-hash fetch), 2 = display/readout path.
- Round-robin arbitration, one transaction at a time, with a per-requester req/ack handshake.
- Sits between the requesters and the RAM. It is the only block driving the RAM address, write-enable and data pins.

Parameters:
DATA_W, 48, RAM word width
ADDR_W, 5, RAM address width
RD_LAT, 2, cycles from the read ISSUE cycle to valid mem_q; must be >= 1

Ports:
clock  input  1  system clock, all state updates on the rising edge
resetn  input  1  asynchronous active-low reset
req  input  3  per-requester request level, bit i = requester i
wr  input  3  bit i: 1 = write, 0 = read; sampled with req[i]
addr_bus  input  3*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
wdata_bus  input  3*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
grant  output  3  one-hot, marks the owner of the transaction in progress
ack  output  3  one-cycle completion pulse to the owner
rdata  output  DATA_W  last captured read data
busy  output  1  high whenever state != IDLE
mem_addr  output  ADDR_W  RAM address
mem_wren  output  1  RAM write enable
mem_data  output  DATA_W  RAM write data
mem_q  input  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, resetn=0), also applies mid-transaction:
  - state=IDLE; grant, ack, mem_wren, busy = 0.
  - rdata, mem_addr, mem_data = 0.
  - Round-robin pointer ptr=2, so requester 0 has top priority first.
  - A transaction in progress is abandoned and no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If req != 0, pick the first set bit in the order ptr+1, ptr+2, ptr (mod 3).
  - Latch idx, wr[idx], addr and wdata of the winner, then go to ISSUE. With req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched addr; mem_data = latched wdata; mem_wren = latched wr.
  - Write goes to ACK; read goes to WAIT with cnt=0.
- WAIT:
  - cnt increments each cycle.
  - When cnt == RD_LAT-1, capture mem_q into rdata at that edge and go to ACK. WAIT therefore lasts RD_LAT cycles.
  - mem_wren = 0.
- ACK (1 cycle):
  - ack[idx]=1; ptr <= idx; go to IDLE.
  - For reads, rdata already holds the new value in this cycle.
- grant[idx] is high from ISSUE through ACK inclusive, and 0 in IDLE.
- mem_wren is high only in ISSUE when the latched op is a write. It is never high in any other state.
- mem_addr and mem_data hold their last latched values outside ISSUE.
- rdata changes only on a read capture; writes leave it unchanged.
- Latency, with req sampled in IDLE at edge 0:
  - Write: mem_wren in cycle 1, ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
  - Minimum spacing between consecutive grants is 3 cycles (write) or 3+RD_LAT cycles (read).
- Handshake rules:
  - Requester i holds req[i], wr[i], address and data until it sees ack[i].
  - req[i] still high in the cycle after ack is a new request and is arbitrated again.
  - Changes to req/wr/addr/wdata after latching are ignored for the current transaction.
  - Dropping req[i] before ack does not cancel the transaction; ack still fires.
- Simultaneous requests are resolved only by the round-robin order. No requester waits more than 2 other transactions.
- An ack never coincides with a grant to a different requester.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with req=3'b111 -> all outputs 0, busy=0; after release requester 0 is granted first.
- Single write: req[0]=1, wr[0]=1, addr 5'd5, data 48'h0000_0000_ABCD -> mem_wren=1 for exactly cycle 1 with mem_addr=5, mem_data=48'hABCD; ack[0] in cycle 2 only; rdata unchanged.
- Read-back, RD_LAT=2: requester 1 reads addr 5 with the RAM model returning 48'hABCD -> grant=3'b010 cycles 1-4, ack[1] in cycle 4, rdata=48'hABCD; mem_wren stays 0.
- Fairness: req=3'b111 held continuously, all writes -> grants in order 0,1,2,0,1,2, spaced 3 cycles apart; no two grant bits ever high together.
- Latched request: requester 2 read, req[2] dropped during WAIT and addr changed -> ack[2] still pulses and the original address was used.
- Reset mid-WAIT: resetn low during WAIT -> outputs 0 immediately, no ack; the next req=3'b110 grants requester 1.

Source files
------------

// File: rtl/ledger_mem_arbiter_if.sv
// Bundle between the three ledger-RAM requesters, the arbiter and the RAM pins.
// The slave side is the arbiter; the master side is everything around it.
interface ledger_mem_arbiter_if #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 5
);
  logic [2:0]          req;
  logic [2:0]          wr;
  logic [3*ADDR_W-1:0] addr_bus;
  logic [3*DATA_W-1:0] wdata_bus;
  logic [2:0]          grant;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wren;
  logic [DATA_W-1:0]   mem_data;
  logic [DATA_W-1:0]   mem_q;

  modport master (
    output req, wr, addr_bus, wdata_bus, mem_q,
    input  grant, ack, rdata, busy, mem_addr, mem_wren, mem_data
  );

  modport slave (
    input  req, wr, addr_bus, wdata_bus, mem_q,
    output grant, ack, rdata, busy, mem_addr, mem_wren, mem_data
  );
endinterface

// File: rtl/ledger_mem_arbiter.sv
// Round-robin owner of the single-port ledger RAM: one transaction at a time,
// IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> ACK, with a per-requester ack pulse.
module ledger_arb_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] idx,
  input  logic       in_txn,
  input  logic       in_ack,
  output logic       grant,
  output logic       ack
);
  logic own;
  assign own   = (idx == 2'(LANE));
  assign grant = in_txn & own;
  assign ack   = in_ack & own;
endmodule

module ledger_mem_arbiter #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  ledger_mem_arbiter_if.slave  bus
);
  localparam int NUM_REQ = 3;
  localparam int CNT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic              wr_op_q, wr_op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              win_vld;
  logic [1:0]        win_idx;

  // Walk ptr+3 down to ptr+1 so the lowest offset with a request wins last.
  always_comb begin : arb_pick
    int c;
    c       = 0;
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req[c]) begin
        win_vld = 1'b1;
        win_idx = 2'(c);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    wr_op_d    = wr_op_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d      = win_idx;
          wr_op_d    = bus.wr[win_idx];
          mem_addr_d = bus.addr_bus[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_data_d = bus.wdata_bus[int'(win_idx)*DATA_W +: DATA_W];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_op_q) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          rdata_d = bus.mem_q;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        ptr_d   = idx_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd2;
      idx_q      <= 2'd0;
      wr_op_q    <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      wr_op_q    <= wr_op_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
    end
  end

  logic                busy_w;
  logic                in_ack_w;
  logic [NUM_REQ-1:0]  grant_w;
  logic [NUM_REQ-1:0]  ack_w;

  assign busy_w   = (state_q != S_IDLE);
  assign in_ack_w = (state_q == S_ACK);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    ledger_arb_lane #(.LANE(i)) u_lane (
      .idx    (idx_q),
      .in_txn (busy_w),
      .in_ack (in_ack_w),
      .grant  (grant_w[i]),
      .ack    (ack_w[i])
    );
  end

  assign bus.grant    = grant_w;
  assign bus.ack      = ack_w;
  assign bus.busy     = busy_w;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.mem_wren = (state_q == S_ISSUE) && wr_op_q;

  a_grant_onehot: assert property (@(posedge clock) disable iff (!resetn)
    $onehot0(grant_w));
  a_ack_owner: assert property (@(posedge clock) disable iff (!resetn)
    (ack_w != '0) |-> (ack_w == grant_w));
  a_wren_issue: assert property (@(posedge clock) disable iff (!resetn)
    bus.mem_wren |-> (state_q == S_ISSUE));
endmodule
